// File: rtl/fetch_issue_unit.sv
// Instruction-fetch front end. It owns the PC and fetches one 32-bit word at
// a time from instruction memory. It then holds that word for the decode stage
// until decode consumes it, and accepts branch/jump redirects from the control
// path. A misaligned redirect target parks the unit in HALT with a sticky
// fault. Only a reset leaves HALT.
module fetch_issue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    // A target is usable only when it addresses a whole 32-bit word.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_valid_q, req_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fault_q, fault_d;

    logic        redirect_ok_s;
    logic        redirect_bad_s;
    logic        req_fire_s;

    assign redirect_ok_s  = redirect & is_word_aligned(redirect_pc);
    assign redirect_bad_s = redirect & ~is_word_aligned(redirect_pc);
    assign req_fire_s     = req_valid_q & imem_req_ready;

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign op             = instr_q[6:0];
    assign instr_pc       = instr_pc_q;
    assign fault          = fault_q;

    // Next-state logic. A redirect outranks every other event in the same cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_valid_d   = req_valid_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;

        if (redirect_bad_s && (state_q != ST_HALT)) begin
            // A misaligned target is unrecoverable, so the PC keeps its old value.
            fault_d       = 1'b1;
            state_d       = ST_HALT;
            req_valid_d   = 1'b0;
            instr_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_ok_s) begin
                        pc_d = redirect_pc;
                    end else begin
                        pc_d = pc_q;
                    end
                    state_d     = ST_REQ;
                    req_valid_d = 1'b1;
                end
                ST_REQ: begin
                    if (redirect_ok_s) begin
                        // Drop valid for a cycle so the address never changes under valid.
                        pc_d        = redirect_pc;
                        req_valid_d = 1'b0;
                        if (req_fire_s) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (req_fire_s) begin
                        req_valid_d = 1'b0;
                        state_d     = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (redirect_ok_s) begin
                        pc_d = redirect_pc;
                        if (imem_rsp_valid) begin
                            // The stale word arrives now, so drop it and fetch the target.
                            state_d     = ST_REQ;
                            req_valid_d = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (imem_rsp_valid) begin
                        instr_d       = imem_rsp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (redirect_ok_s) begin
                        // Squash the held word; it is not counted as consumed.
                        pc_d          = redirect_pc;
                        instr_valid_d = 1'b0;
                        state_d       = ST_REQ;
                        req_valid_d   = 1'b1;
                    end else if (instr_ready) begin
                        pc_d          = pc_q + PC_INC;
                        instr_valid_d = 1'b0;
                        state_d       = ST_REQ;
                        req_valid_d   = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_ok_s) begin
                        pc_d = redirect_pc;
                    end else begin
                        pc_d = pc_q;
                    end
                    if (imem_rsp_valid) begin
                        // The outstanding response is discarded; fetch the redirect target.
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    state_d       = ST_HALT;
                    req_valid_d   = 1'b0;
                    instr_valid_d = 1'b0;
                end
                default: begin
                    state_d       = ST_IDLE;
                    req_valid_d   = 1'b0;
                    instr_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit. Inputs change on the falling edge and
// outputs are checked on the falling edge, half a cycle after the rising edge
// that produced them.
module tb_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;

    fetch_issue_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .op             (op),
        .instr_pc       (instr_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    // Free-running clock with a period of 10 time units.
    always #5 clk = ~clk;

    // Safety net so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", instr); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault: got %b want 0", fault); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", imem_req_addr); end
        rst_n = 1'b1;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL idle_req_valid: got %b want 0", imem_req_valid); end
        tick();
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL first_req_addr: got %h want 0", imem_req_addr); end
    endtask

    task automatic test_basic;
        logic [31:0] words [2];
        logic [6:0]  ops   [2];
        words[0] = 32'h0000_0013; ops[0] = 7'b0010011;
        words[1] = 32'h0000_0033; ops[1] = 7'b0110011;
        for (int i = 0; i < 2; i++) begin
            imem_req_ready = 1'b1;
            tick();
            imem_req_ready = 1'b0;
            vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL basic_wait_req_valid[%0d]: got %b want 0", i, imem_req_valid); end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = words[i];
            tick();
            imem_rsp_valid = 1'b0;
            vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL basic_instr_valid[%0d]: got %b want 1", i, instr_valid); end
            vectors++; if (op !== ops[i]) begin miscompares++; $display("FAIL basic_op[%0d]: got %b want %b", i, op, ops[i]); end
            vectors++; if (instr_pc !== 32'(i * 4)) begin miscompares++; $display("FAIL basic_instr_pc[%0d]: got %h want %h", i, instr_pc, 32'(i * 4)); end
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL basic_next_req[%0d]: got %b want 1", i, imem_req_valid); end
            vectors++; if (imem_req_addr !== 32'((i + 1) * 4)) begin miscompares++; $display("FAIL basic_next_addr[%0d]: got %h want %h", i, imem_req_addr, 32'((i + 1) * 4)); end
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL basic_consumed[%0d]: got %b want 0", i, instr_valid); end
        end
    endtask

    task automatic test_hold_redirect;
        // Fetch the word at 8, then redirect to 0x40 in the same cycle as the consume.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0063;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++; if (instr_pc !== 32'h8) begin miscompares++; $display("FAIL hr_instr_pc: got %h want 8", instr_pc); end
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        instr_ready = 1'b0;
        redirect    = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL hr_instr_valid: got %b want 0", instr_valid); end
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL hr_req_valid: got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h40) begin miscompares++; $display("FAIL hr_req_addr: got %h want 40", imem_req_addr); end
    endtask

    task automatic test_req_stall;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL stall_req_valid[%0d]: got %b want 1", i, imem_req_valid); end
            vectors++; if (imem_req_addr !== 32'h40) begin miscompares++; $display("FAIL stall_req_addr[%0d]: got %h want 40", i, imem_req_addr); end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_early_valid[%0d]: got %b want 0", i, instr_valid); end
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0093;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_instr_valid: got %b want 1", instr_valid); end
        vectors++; if (instr !== 32'h00A0_0093) begin miscompares++; $display("FAIL stall_instr: got %h want 00a00093", instr); end
        vectors++; if (instr_pc !== 32'h40) begin miscompares++; $display("FAIL stall_instr_pc: got %h want 40", instr_pc); end
    endtask

    task automatic test_hold_stall;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b want 1", i, instr_valid); end
            vectors++; if (instr !== 32'h00A0_0093) begin miscompares++; $display("FAIL hold_instr[%0d]: got %h want 00a00093", i, instr); end
            vectors++; if (op !== 7'b0010011) begin miscompares++; $display("FAIL hold_op[%0d]: got %b want 0010011", i, op); end
            vectors++; if (instr_pc !== 32'h40) begin miscompares++; $display("FAIL hold_instr_pc[%0d]: got %h want 40", i, instr_pc); end
            vectors++; if (imem_req_addr !== 32'h40) begin miscompares++; $display("FAIL hold_pc[%0d]: got %h want 40", i, imem_req_addr); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors++; if (imem_req_addr !== 32'h44) begin miscompares++; $display("FAIL hold_pc_after: got %h want 44", imem_req_addr); end
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL hold_req_after: got %b want 1", imem_req_valid); end
    endtask

    task automatic test_wait_redirect;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        tick();
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL wr_drain_req: got %b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_006F;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL wr_stale_valid: got %b want 0", instr_valid); end
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL wr_req_valid: got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL wr_req_addr: got %h want 100", imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0037;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++; if (instr !== 32'h0000_0037) begin miscompares++; $display("FAIL wr_new_instr: got %h want 00000037", instr); end
        vectors++; if (instr_pc !== 32'h100) begin miscompares++; $display("FAIL wr_new_pc: got %h want 100", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_req_redirect;
        vectors++; if (imem_req_addr !== 32'h104) begin miscompares++; $display("FAIL rr_start_addr: got %h want 104", imem_req_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rr_gap: got %b want 0", imem_req_valid); end
        tick();
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rr_req_valid: got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL rr_req_addr: got %h want 200", imem_req_addr); end
    endtask

    task automatic test_misaligned;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault: got %b want 1", fault); end
        vectors++; if (imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL mis_pc: got %h want 200", imem_req_addr); end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL halt_req_valid[%0d]: got %b want 0", i, imem_req_valid); end
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_instr_valid[%0d]: got %b want 0", i, instr_valid); end
            vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL halt_fault[%0d]: got %b want 1", i, fault); end
            tick();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL mis_reset_fault: got %b want 0", fault); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        vectors++; if (imem_req_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h want fffffffc", imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++; if (instr_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_instr_pc: got %h want fffffffc", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_req_valid: got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr: got %h want 0", imem_req_addr); end
    endtask

    // Test sequence.
    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_hold_redirect();
        test_req_stall();
        test_hold_stall();
        test_wait_redirect();
        test_req_redirect();
        test_misaligned();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
